// File: rtl/opb_stage.sv
// opb_stage: stage-2 to stage-3 operand-B register with forward capture across stalls
module opb_stage #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [31:0]      d_inst,
    input  logic [31:0]      d_pc,
    input  logic [1:0]       BSelSignal,
    input  logic [31:0]      rs2_data,
    input  logic [31:0]      imm,
    input  logic [31:0]      w_alu_result,
    input  logic [31:0]      w_load_data,
    output logic [31:0]      x_op_b,
    output logic [31:0]      x_store_data,
    output logic [31:0]      x_inst,
    output logic [31:0]      x_pc,
    output logic             x_valid,
    output logic [CNT_W-1:0] fwd_alu_cnt,
    output logic [CNT_W-1:0] fwd_ld_cnt
);
    typedef enum logic {RUN, HELD} state_t;

    state_t           state_q, state_d;
    logic [31:0]      hold_b_q, hold_b_d, hold_sd_q, hold_sd_d;
    logic [1:0]       hold_sel_q, hold_sel_d;
    logic [31:0]      op_b_q, op_b_d, sd_q, sd_d, inst_q, inst_d, pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, ld_cnt_q, ld_cnt_d;
    logic [31:0]      mux_b, fwd_val;
    logic [1:0]       sel_c;
    logic             held, adv;

    // Next-state: the forward source retires during a stall, so it is captured on stall entry
    always_comb begin
        mux_b      = BSelSignal[1] ? (BSelSignal[0] ? w_load_data : w_alu_result)
                                   : (BSelSignal[0] ? imm : rs2_data);
        fwd_val    = BSelSignal[1] ? mux_b : rs2_data;
        held       = state_q == HELD;
        adv        = !stall && !flush;
        sel_c      = held ? hold_sel_q : BSelSignal;
        state_d    = state_q;
        hold_b_d   = hold_b_q;
        hold_sd_d  = hold_sd_q;
        hold_sel_d = hold_sel_q;
        op_b_d     = op_b_q;
        sd_d       = sd_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        if (flush) begin
            state_d    = RUN;
            hold_b_d   = '0;
            hold_sd_d  = '0;
            hold_sel_d = '0;
            op_b_d     = '0;
            sd_d       = '0;
            inst_d     = NOP_INST;
            valid_d    = 1'b0;
        end else if (stall) begin
            if (!held && d_valid && BSelSignal[1]) begin
                state_d    = HELD;
                hold_b_d   = mux_b;
                hold_sd_d  = fwd_val;
                hold_sel_d = BSelSignal;
            end
        end else begin
            state_d = RUN;
            op_b_d  = held ? hold_b_q : mux_b;
            sd_d    = held ? hold_sd_q : fwd_val;
            inst_d  = d_inst;
            pc_d    = d_pc;
            valid_d = d_valid;
        end
        alu_cnt_d = (adv && d_valid && sel_c == 2'b10 && !(&alu_cnt_q)) ? alu_cnt_q + CNT_W'(1) : alu_cnt_q;
        ld_cnt_d  = (adv && d_valid && sel_c == 2'b11 && !(&ld_cnt_q)) ? ld_cnt_q + CNT_W'(1) : ld_cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            hold_b_q   <= '0;
            hold_sd_q  <= '0;
            hold_sel_q <= '0;
            op_b_q     <= '0;
            sd_q       <= '0;
            inst_q     <= NOP_INST;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            alu_cnt_q  <= '0;
            ld_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_b_q   <= hold_b_d;
            hold_sd_q  <= hold_sd_d;
            hold_sel_q <= hold_sel_d;
            op_b_q     <= op_b_d;
            sd_q       <= sd_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            alu_cnt_q  <= alu_cnt_d;
            ld_cnt_q   <= ld_cnt_d;
        end
    end

    assign x_op_b       = op_b_q;
    assign x_store_data = sd_q;
    assign x_inst       = inst_q;
    assign x_pc         = pc_q;
    assign x_valid      = valid_q;
    assign fwd_alu_cnt  = alu_cnt_q;
    assign fwd_ld_cnt   = ld_cnt_q;
endmodule

// File: tb/tb_opb_stage.sv
// tb_opb_stage: directed checks of operand-B capture, flush, reset and counter saturation
module tb_opb_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, d_valid;
    logic [31:0] d_inst, d_pc, rs2_data, imm, w_alu_result, w_load_data;
    logic [1:0]  BSelSignal;
    logic [31:0] x_op_b, x_store_data, x_inst, x_pc;
    logic        x_valid;
    logic [15:0] fwd_alu_cnt, fwd_ld_cnt;
    logic [31:0] s_op_b, s_store_data, s_inst, s_pc;
    logic        s_valid;
    logic [1:0]  s_alu_cnt, s_ld_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    opb_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d_valid(d_valid),
        .d_inst(d_inst), .d_pc(d_pc), .BSelSignal(BSelSignal), .rs2_data(rs2_data),
        .imm(imm), .w_alu_result(w_alu_result), .w_load_data(w_load_data),
        .x_op_b(x_op_b), .x_store_data(x_store_data), .x_inst(x_inst), .x_pc(x_pc),
        .x_valid(x_valid), .fwd_alu_cnt(fwd_alu_cnt), .fwd_ld_cnt(fwd_ld_cnt)
    );

    opb_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .d_valid(d_valid),
        .d_inst(d_inst), .d_pc(d_pc), .BSelSignal(BSelSignal), .rs2_data(rs2_data),
        .imm(imm), .w_alu_result(w_alu_result), .w_load_data(w_load_data),
        .x_op_b(s_op_b), .x_store_data(s_store_data), .x_inst(s_inst), .x_pc(s_pc),
        .x_valid(s_valid), .fwd_alu_cnt(s_alu_cnt), .fwd_ld_cnt(s_ld_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; d_valid = 1'b0;
        d_inst = '0; d_pc = '0; BSelSignal = 2'b00; rs2_data = '0; imm = '0;
        w_alu_result = '0; w_load_data = '0;
        step(); step();
        check("rst_op_b", x_op_b, 32'h0);
        check("rst_sd", x_store_data, 32'h0);
        check("rst_inst", x_inst, 32'h00000013);
        check("rst_pc", x_pc, 32'h0);
        check("rst_valid", {31'b0, x_valid}, 32'h0);
        check("rst_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h0);
        check("rst_ld_cnt", {16'b0, fwd_ld_cnt}, 32'h0);
        rst = 1'b0;
        // plain advance with immediate
        BSelSignal = 2'b01; imm = 32'h10; rs2_data = 32'h55; d_valid = 1'b1;
        d_inst = 32'h00a00093; d_pc = 32'h100;
        step();
        check("adv_op_b", x_op_b, 32'h10);
        check("adv_sd", x_store_data, 32'h55);
        check("adv_valid", {31'b0, x_valid}, 32'h1);
        check("adv_inst", x_inst, 32'h00a00093);
        check("adv_pc", x_pc, 32'h100);
        check("adv_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h0);
        // stalled ALU forward, source changes while held
        BSelSignal = 2'b10; w_alu_result = 32'hAAAA0000; d_pc = 32'h104; stall = 1'b1;
        step();
        w_alu_result = 32'h5;
        step(); step();
        check("stall_op_b_hold", x_op_b, 32'h10);
        check("stall_pc_hold", x_pc, 32'h100);
        stall = 1'b0;
        step();
        check("fwd_op_b", x_op_b, 32'hAAAA0000);
        check("fwd_sd", x_store_data, 32'hAAAA0000);
        check("fwd_pc", x_pc, 32'h104);
        check("fwd_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h1);
        // load forward into store data
        BSelSignal = 2'b11; w_load_data = 32'h1234; rs2_data = 32'h99;
        step();
        check("ld_sd", x_store_data, 32'h1234);
        check("ld_cnt", {16'b0, fwd_ld_cnt}, 32'h1);
        check("ld_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h1);
        // flush while held
        BSelSignal = 2'b10; w_alu_result = 32'h77; stall = 1'b1;
        step();
        flush = 1'b1;
        step();
        check("flush_inst", x_inst, 32'h00000013);
        check("flush_valid", {31'b0, x_valid}, 32'h0);
        check("flush_op_b", x_op_b, 32'h0);
        check("flush_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h1);
        flush = 1'b0; stall = 1'b0; w_alu_result = 32'h88;
        step();
        check("post_flush_op_b", x_op_b, 32'h88);
        check("post_flush_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h2);
        // invalid instruction: no count, no capture
        d_valid = 1'b0; stall = 1'b1; w_alu_result = 32'h11;
        step();
        w_alu_result = 32'h22; stall = 1'b0;
        step();
        check("inv_op_b", x_op_b, 32'h22);
        check("inv_valid", {31'b0, x_valid}, 32'h0);
        check("inv_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h2);
        // reset while held
        d_valid = 1'b1; w_alu_result = 32'hDEAD; stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0; BSelSignal = 2'b00; rs2_data = 32'h7;
        step();
        check("rst_held_op_b", x_op_b, 32'h7);
        check("rst_held_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h0);
        // saturation on the 2-bit instance
        BSelSignal = 2'b10; w_alu_result = 32'h1;
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt", {30'b0, s_alu_cnt}, 32'h3);
        check("wide_cnt", {16'b0, fwd_alu_cnt}, 32'h5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/opb_stage.md
OPB_STAGE -- requirements
Module: opb_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h00000013, the instruction word loaded on reset and flush.
REQ-002 SHALL have parameter CNT_W, default 16, the forwarding-counter width.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 stall  in  1  hold stage-2 to stage-3 register contents.
REQ-007 flush  in  1  kill the instruction entering stage 3 (taken branch or jump).
REQ-008 d_valid  in  1  stage-2 holds a real instruction.
REQ-009 d_inst  in  32  stage-2 instruction.
REQ-010 d_pc  in  32  stage-2 PC.
REQ-011 BSelSignal  in  2  operand-B select: 00 rs2_data, 01 imm, 10 w_alu_result, 11 w_load_data.
REQ-012 rs2_data  in  32  regfile rs2 read data.
REQ-013 imm  in  32  stage-2 sign-extended immediate.
REQ-014 w_alu_result  in  32  stage-3 ALU result (forward source).
REQ-015 w_load_data  in  32  stage-3 formatted load data (forward source).
REQ-016 x_op_b  out  32  registered operand B.
REQ-017 x_store_data  out  32  registered store data.
REQ-018 x_inst  out  32  registered instruction.
REQ-019 x_pc  out  32  registered PC.
REQ-020 x_valid  out  1  registered valid.
REQ-021 fwd_alu_cnt  out  CNT_W  saturating count of committed 10 selects.
REQ-022 fwd_ld_cnt  out  CNT_W  saturating count of committed 11 selects.

Function
REQ-023 mux_b SHALL be rs2_data, imm, w_alu_result or w_load_data for BSelSignal 00, 01, 10 or 11 respectively.
REQ-024 fwd_val SHALL be mux_b when BSelSignal is 10 or 11, else rs2_data.
REQ-025 Two states SHALL exist: RUN and HELD.
REQ-026 In RUN with stall=1, flush=0, d_valid=1 and BSelSignal[1]=1: SHALL capture mux_b into hold_b and fwd_val into hold_sd, then go to HELD.
REQ-027 The capture in REQ-026 is required because the forward source retires while stage 2 is stalled.
REQ-028 In RUN with stall=1 and no capture condition: SHALL stay in RUN.
REQ-029 In HELD with stall=1: SHALL stay in HELD and keep hold_b and hold_sd unchanged.
REQ-030 In HELD, the values loaded into x_op_b and x_store_data SHALL be hold_b and hold_sd, not the live mux.
REQ-031 Advance (stall=0, flush=0): SHALL load x_op_b and x_store_data from the source per REQ-030, else from mux_b and fwd_val.
REQ-032 On advance, SHALL load x_inst=d_inst, x_pc=d_pc, x_valid=d_valid, and go to RUN.
REQ-033 While stall=1 and flush=0: all x_* registers SHALL hold their values.
REQ-034 Flush: SHALL load x_inst=NOP_INST, x_valid=0, x_op_b=0, x_store_data=0; state=RUN; hold registers discarded.
REQ-035 Priority SHALL be rst > flush > stall > advance; flush during HELD returns to RUN in the same edge.
REQ-036 Counters SHALL increment only on an advance edge with d_valid=1: fwd_alu_cnt when the committed select is 10, fwd_ld_cnt when it is 11.
REQ-037 In HELD, the committed select SHALL be the select captured at entry.
REQ-038 Counters SHALL saturate at all-ones and never wrap.
REQ-039 Latency SHALL be one cycle from stage-2 inputs to x_* outputs; there is no combinational path from inputs to outputs.

Reset
REQ-040 On rst: x_op_b=0, x_store_data=0, x_inst=NOP_INST, x_pc=0, x_valid=0, both counters 0, hold registers 0, state RUN.
REQ-041 rst asserted in HELD SHALL discard the held value; the first post-reset advance uses the live mux.

Verification
REQ-042 Plain advance: BSel=01, imm=0x10, d_valid=1 -> next cycle x_op_b=0x10, x_valid=1, counters unchanged.
REQ-043 Stalled forward: BSel=10, w_alu_result=0xAAAA0000, stall=1 for 3 cycles while w_alu_result changes to 0x5 -> after release, x_op_b=0xAAAA0000 and fwd_alu_cnt=1.
REQ-044 Load forward to store: store with BSel=11, w_load_data=0x1234 -> x_store_data=0x1234, fwd_ld_cnt=1.
REQ-045 Flush during HELD: flush=1 and stall=1 -> x_inst=0x00000013, x_valid=0, state RUN, no counter increment.
REQ-046 Saturation: CNT_W=2, 5 committed BSel=10 advances -> fwd_alu_cnt=3.
REQ-047 Reset mid-HELD: rst for 1 cycle, then BSel=00, rs2_data=0x7 advance -> x_op_b=0x7.
